// File: rtl/sr_pulse_driver_pkg.sv
// Shared types and default constants for the SR latch pulse driver.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SET_PULSE = 2'd1,
    RST_PULSE = 2'd2,
    GAP       = 2'd3
  } state_e;

  localparam int unsigned DEB_CYCLES_DEF = 500000;
  localparam int unsigned PULSE_W_DEF    = 4;
  localparam int unsigned GAP_W_DEF      = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_pulse_driver_if.sv
// Button inputs and latch-side outputs of the pulse driver.
// pulse_cnt exists only when SR_DRV_PULSE_CNT_EN is defined.
interface sr_pulse_driver_if;
  import sr_drv_pkg::*;

  logic   btn_set;
  logic   btn_rst;
  logic   S_n;
  logic   R_n;
  logic   busy;
  logic   conflict;
  state_e state_dbg;
`ifdef SR_DRV_PULSE_CNT_EN
  logic [7:0] pulse_cnt;
`endif

  // Board/bench side drives the buttons and observes the latch pulses.
  modport master (
    output btn_set, btn_rst,
    input  S_n, R_n, busy, conflict, state_dbg
`ifdef SR_DRV_PULSE_CNT_EN
    , input pulse_cnt
`endif
  );

  modport slave (
    input  btn_set, btn_rst,
    output S_n, R_n, busy, conflict, state_dbg
`ifdef SR_DRV_PULSE_CNT_EN
    , output pulse_cnt
`endif
  );

endinterface

// File: rtl/sr_debounce.sv
// Two-flop synchronizer plus debouncer for one raw button; emits a registered
// one-cycle strobe on each accepted rising level.
module sr_debounce
  import sr_drv_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // The level flips on the DEB_CYCLES-th consecutive mismatched cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
          rise  <= sync2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sr_pulse_driver.sv
// Debounced buttons -> non-overlapping active-low S_n/R_n pulses for a NAND SR latch.
// Optional issued-pulse counter enabled by SR_DRV_PULSE_CNT_EN.
module sr_pulse_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned PULSE_W    = PULSE_W_DEF,
  parameter int unsigned GAP_W      = GAP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  sr_pulse_driver_if.slave  bus
);

  localparam int unsigned TW = $clog2(max_u(PULSE_W, GAP_W) + 1);

  logic          set_rise;
  logic          rst_rise;
  logic          set_pend;
  logic          rst_pend;
  logic          take_set;
  logic          take_rst;
  logic          can_start;
  logic          s_n_q;
  logic          r_n_q;
  logic          conflict_q;
  state_e        state;
  state_e        next_state;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] next_tcnt;

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk  (clk),
    .rst  (rst),
    .btn  (bus.btn_set),
    .rise (set_rise)
  );

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
    .clk  (clk),
    .rst  (rst),
    .btn  (bus.btn_rst),
    .rise (rst_rise)
  );

  // The end of GAP arbitrates like IDLE so queued requests follow back-to-back.
  always_comb begin
    next_state = state;
    next_tcnt  = tcnt;
    can_start  = 1'b0;
    take_set   = 1'b0;
    take_rst   = 1'b0;
    case (state)
      IDLE: can_start = 1'b1;
      SET_PULSE, RST_PULSE: begin
        if (tcnt == TW'(PULSE_W - 1)) begin
          next_state = GAP;
          next_tcnt  = '0;
        end else begin
          next_tcnt = tcnt + TW'(1);
        end
      end
      GAP: begin
        if (tcnt == TW'(GAP_W - 1)) begin
          next_state = IDLE;
          next_tcnt  = '0;
          can_start  = 1'b1;
        end else begin
          next_tcnt = tcnt + TW'(1);
        end
      end
      default: next_state = IDLE;
    endcase
    if (can_start) begin
      if (rst_pend) begin
        next_state = RST_PULSE;
        next_tcnt  = '0;
        take_rst   = 1'b1;
      end else if (set_pend) begin
        next_state = SET_PULSE;
        next_tcnt  = '0;
        take_set   = 1'b1;
      end
    end
  end

  // A strobe arriving while its flag is already set is merged into it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      s_n_q      <= 1'b1;
      r_n_q      <= 1'b1;
      set_pend   <= 1'b0;
      rst_pend   <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state      <= next_state;
      tcnt       <= next_tcnt;
      s_n_q      <= (next_state != SET_PULSE);
      r_n_q      <= (next_state != RST_PULSE);
      set_pend   <= set_pend ? ~take_set : set_rise;
      rst_pend   <= rst_pend ? ~take_rst : rst_rise;
      conflict_q <= set_rise & rst_rise;
    end
  end

`ifdef SR_DRV_PULSE_CNT_EN
  logic [7:0] pulse_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_cnt_q <= 8'd0;
    end else if (take_set || take_rst) begin
      pulse_cnt_q <= pulse_cnt_q + 8'd1;
    end
  end

  assign bus.pulse_cnt = pulse_cnt_q;
`endif

  assign bus.S_n       = s_n_q;
  assign bus.R_n       = r_n_q;
  assign bus.busy      = (state != IDLE);
  assign bus.conflict  = conflict_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Bench for sr_pulse_driver: scenario tasks plus a cycle-level reference model
// that schedules pulses as time intervals. Pulse-counter checks need SR_DRV_PULSE_CNT_EN.
module tb_sr_pulse_driver;
  import sr_drv_pkg::*;

  localparam int DEB = 4;
  localparam int PW  = 3;
  localparam int GW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sr_pulse_driver_if bus_if();

  sr_pulse_driver #(.DEB_CYCLES(DEB), .PULSE_W(PW), .GAP_W(GW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: index 0 = set button, 1 = reset button.
  int         edge_n = 0;
  logic       m_d1[2];
  logic       m_d2[2];
  logic       m_deb[2];
  logic       m_strobe[2];
  logic       m_pend[2];
  int         m_run[2];
  logic       m_conf;
  bit         m_pv;
  int         m_pstart;
  int         m_pkind;
  logic [7:0] m_pcnt;

  task automatic model_edge();
    logic raw[2];
    int   take;
    raw[0] = bus_if.btn_set;
    raw[1] = bus_if.btn_rst;
    edge_n++;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        m_d1[b] = 1'b0; m_d2[b] = 1'b0; m_deb[b] = 1'b0;
        m_strobe[b] = 1'b0; m_pend[b] = 1'b0; m_run[b] = 0;
      end
      m_conf = 1'b0;
      m_pv   = 1'b0;
      m_pcnt = 8'd0;
      return;
    end
    // A pulse may start once the previous pulse and its gap have elapsed.
    take = -1;
    if (!m_pv || edge_n >= m_pstart + PW + GW) begin
      if (m_pend[1]) take = 1;
      else if (m_pend[0]) take = 0;
    end
    if (take >= 0) begin
      m_pv     = 1'b1;
      m_pstart = edge_n;
      m_pkind  = take;
      m_pcnt   = m_pcnt + 8'd1;
    end
    m_conf = m_strobe[0] & m_strobe[1];
    for (int b = 0; b < 2; b++) begin
      m_pend[b] = m_pend[b] ? (take != b) : m_strobe[b];
      m_strobe[b] = 1'b0;
      if (m_d2[b] != m_deb[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_deb[b]    = m_d2[b];
          m_run[b]    = 0;
          m_strobe[b] = m_deb[b];
        end
      end else begin
        m_run[b] = 0;
      end
      m_d2[b] = m_d1[b];
      m_d1[b] = raw[b];
    end
  endtask

  // Advance one clock and compare every output with the model.
  task automatic step();
    logic exp_s, exp_r, exp_b;
    @(posedge clk);
    model_edge();
    #1;
    exp_s = !(m_pv && m_pkind == 0 && edge_n < m_pstart + PW);
    exp_r = !(m_pv && m_pkind == 1 && edge_n < m_pstart + PW);
    exp_b = m_pv && (edge_n < m_pstart + PW + GW);
    tests_run++;
    if (bus_if.S_n !== exp_s) begin
      tests_failed++;
      $display("FAIL s_n edge %0d: got %b expected %b", edge_n, bus_if.S_n, exp_s);
    end
    tests_run++;
    if (bus_if.R_n !== exp_r) begin
      tests_failed++;
      $display("FAIL r_n edge %0d: got %b expected %b", edge_n, bus_if.R_n, exp_r);
    end
    tests_run++;
    if (bus_if.busy !== exp_b) begin
      tests_failed++;
      $display("FAIL busy edge %0d: got %b expected %b", edge_n, bus_if.busy, exp_b);
    end
    tests_run++;
    if (bus_if.conflict !== m_conf) begin
      tests_failed++;
      $display("FAIL conflict edge %0d: got %b expected %b", edge_n, bus_if.conflict, m_conf);
    end
    tests_run++;
    if ((bus_if.S_n | bus_if.R_n) !== 1'b1) begin
      tests_failed++;
      $display("FAIL both_low edge %0d: S_n=%b R_n=%b", edge_n, bus_if.S_n, bus_if.R_n);
    end
`ifdef SR_DRV_PULSE_CNT_EN
    tests_run++;
    if (bus_if.pulse_cnt !== m_pcnt) begin
      tests_failed++;
      $display("FAIL pulse_cnt edge %0d: got %0d expected %0d", edge_n, bus_if.pulse_cnt, m_pcnt);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.btn_set = 1'b1;
    bus_if.btn_rst = 1'b1;
    repeat (2) begin
      step();
      tests_run++;
      if ({bus_if.S_n, bus_if.R_n, bus_if.busy, bus_if.conflict} !== 4'b1100) begin
        tests_failed++;
        $display("FAIL reset_outputs: got %b expected 1100",
                 {bus_if.S_n, bus_if.R_n, bus_if.busy, bus_if.conflict});
      end
      tests_run++;
      if (bus_if.state_dbg !== IDLE) begin
        tests_failed++;
        $display("FAIL reset_state: got %0d expected %0d", bus_if.state_dbg, IDLE);
      end
`ifdef SR_DRV_PULSE_CNT_EN
      tests_run++;
      if (bus_if.pulse_cnt !== 8'd0) begin
        tests_failed++;
        $display("FAIL reset_pulse_cnt: got %0d expected 0", bus_if.pulse_cnt);
      end
`endif
    end
    rst = 1'b0;
    bus_if.btn_set = 1'b0;
    bus_if.btn_rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      tests_run++;
      if ({bus_if.S_n, bus_if.R_n} !== 2'b11) begin
        tests_failed++;
        $display("FAIL reset_no_pulse cycle %0d: got %b expected 11", k, {bus_if.S_n, bus_if.R_n});
      end
    end
  endtask

  task automatic test_clean_set();
    int busy_cyc = 0;
    bus_if.btn_set = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      busy_cyc += int'(bus_if.busy);
      tests_run++;
      if (bus_if.S_n !== ((k >= DEB + 3 && k < DEB + 3 + PW) ? 1'b0 : 1'b1)) begin
        tests_failed++;
        $display("FAIL clean_set_timing edge %0d: got S_n=%b", k, bus_if.S_n);
      end
    end
    tests_run++;
    if (busy_cyc != PW + GW) begin
      tests_failed++;
      $display("FAIL clean_set_busy: got %0d cycles expected %0d", busy_cyc, PW + GW);
    end
    bus_if.btn_set = 1'b0;
    repeat (20) step();
  endtask

  task automatic test_bounce();
    int first = -1;
    int lows  = 0;
    for (int i = 0; i < 20; i++) begin
      bus_if.btn_set = ((i / 2) % 2 == 0);
      step();
      tests_run++;
      if (bus_if.S_n !== 1'b1) begin
        tests_failed++;
        $display("FAIL bounce_quiet cycle %0d: got S_n=%b expected 1", i, bus_if.S_n);
      end
    end
    bus_if.btn_set = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (bus_if.S_n === 1'b0) begin
        lows++;
        if (first < 0) first = k;
      end
    end
    tests_run++;
    if (first != DEB + 3) begin
      tests_failed++;
      $display("FAIL bounce_latency: got %0d expected %0d", first, DEB + 3);
    end
    tests_run++;
    if (lows != PW) begin
      tests_failed++;
      $display("FAIL bounce_single_pulse: got %0d low cycles expected %0d", lows, PW);
    end
    bus_if.btn_set = 1'b0;
    repeat (20) step();
  endtask

  task automatic test_simultaneous();
    int conf_cnt = 0;
    int r_first  = -1;
    int s_first  = -1;
    int r_lows   = 0;
    int s_lows   = 0;
    bus_if.btn_set = 1'b1;
    bus_if.btn_rst = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step();
      conf_cnt += int'(bus_if.conflict);
      if (bus_if.R_n === 1'b0) begin r_lows++; if (r_first < 0) r_first = k; end
      if (bus_if.S_n === 1'b0) begin s_lows++; if (s_first < 0) s_first = k; end
    end
    tests_run++;
    if (conf_cnt != 1) begin
      tests_failed++;
      $display("FAIL simul_conflict: got %0d strobes expected 1", conf_cnt);
    end
    tests_run++;
    if (r_first != DEB + 3 || r_lows != PW) begin
      tests_failed++;
      $display("FAIL simul_rst_first: got start %0d len %0d expected %0d len %0d", r_first, r_lows, DEB + 3, PW);
    end
    tests_run++;
    if (s_first != r_first + PW + GW || s_lows != PW) begin
      tests_failed++;
      $display("FAIL simul_set_second: got start %0d len %0d expected %0d len %0d",
               s_first, s_lows, r_first + PW + GW, PW);
    end
    bus_if.btn_set = 1'b0;
    bus_if.btn_rst = 1'b0;
    repeat (20) step();
  endtask

  task automatic test_back_to_back();
    int r_first = -1;
    int s_first = -1;
    int r_lows  = 0;
    bus_if.btn_set = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (k == 3) bus_if.btn_rst = 1'b1;
      step();
      if (bus_if.R_n === 1'b0) begin r_lows++; if (r_first < 0) r_first = k; end
      if (bus_if.S_n === 1'b0 && s_first < 0) s_first = k;
    end
    tests_run++;
    if (s_first != DEB + 3) begin
      tests_failed++;
      $display("FAIL b2b_set_start: got %0d expected %0d", s_first, DEB + 3);
    end
    tests_run++;
    if (r_first != DEB + 3 + PW + GW || r_lows != PW) begin
      tests_failed++;
      $display("FAIL b2b_rst_after_gap: got start %0d len %0d expected %0d len %0d",
               r_first, r_lows, DEB + 3 + PW + GW, PW);
    end
    bus_if.btn_set = 1'b0;
    bus_if.btn_rst = 1'b0;
    repeat (20) step();
  endtask

`ifdef SR_DRV_PULSE_CNT_EN
  task automatic test_pulse_cnt_wrap();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 257; i++) begin
      if (i % 2 == 0) bus_if.btn_set = 1'b1;
      else            bus_if.btn_rst = 1'b1;
      repeat (8) step();
      bus_if.btn_set = 1'b0;
      bus_if.btn_rst = 1'b0;
      repeat (8) step();
    end
    repeat (10) step();
    tests_run++;
    if (bus_if.pulse_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL pulse_cnt_wrap: got %0d expected 1", bus_if.pulse_cnt);
    end
  endtask
`endif

  task automatic test_abort();
    int n = 0;
    bus_if.btn_set = 1'b1;
    do begin
      step();
      n++;
    end while (bus_if.S_n !== 1'b0 && n < 20);
    tests_run++;
    if (bus_if.S_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_wait: S_n never went low within %0d cycles", n);
    end
    step();
    rst = 1'b1;
    bus_if.btn_set = 1'b0;
    step();
    tests_run++;
    if ({bus_if.S_n, bus_if.R_n, bus_if.busy} !== 3'b110) begin
      tests_failed++;
      $display("FAIL abort_outputs: got %b expected 110", {bus_if.S_n, bus_if.R_n, bus_if.busy});
    end
`ifdef SR_DRV_PULSE_CNT_EN
    tests_run++;
    if (bus_if.pulse_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL abort_pulse_cnt: got %0d expected 0", bus_if.pulse_cnt);
    end
`endif
    rst = 1'b0;
    repeat (20) step();
  endtask

  task automatic test_random();
    int rate = 6;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) rate = int'($urandom_range(2, 12));
      if ($urandom_range(0, rate - 1) == 0) bus_if.btn_set = ~bus_if.btn_set;
      if ($urandom_range(0, rate - 1) == 0) bus_if.btn_rst = ~bus_if.btn_rst;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    bus_if.btn_set = 1'b0;
    bus_if.btn_rst = 1'b0;
    repeat (20) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_if.btn_set = 1'b0;
    bus_if.btn_rst = 1'b0;
    test_reset();
    test_clean_set();
    test_bounce();
    test_simultaneous();
    test_back_to_back();
`ifdef SR_DRV_PULSE_CNT_EN
    test_pulse_cnt_wrap();
`endif
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sr_pulse_driver.md
Name: sr_pulse_driver

Overview:
- Upstream stage for the NAND-style SR latch, whose set and reset inputs are active-low.
- Converts two asynchronous, bouncing pushbutton inputs into clean, registered, active-low set/reset pulses.
- Guarantees the latch never sees both inputs low at once.
- Sits between the board buttons and the latch's S/R inputs; the outputs connect directly to the latch.

Parameters:
- DEB_CYCLES, 500000, consecutive stable cycles required to accept a new button level (5 ms at 100 MHz).
- PULSE_W, 4, cycles that S_n or R_n is held low per event (>=1).
- GAP_W, 2, cycles with both outputs high after any pulse, before the next pulse may start (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_set  in  1  raw set button, asynchronous, active-high.
- btn_rst  in  1  raw reset button, asynchronous, active-high.
- S_n  out  1  active-low set pulse to the latch; registered.
- R_n  out  1  active-low reset pulse to the latch; registered.
- busy  out  1  high whenever the FSM is not in IDLE.
- conflict  out  1  one-cycle strobe when set and reset requests arise on the same cycle.
- pulse_cnt  out  8  issued-pulse count; present only with SR_DRV_PULSE_CNT_EN.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) sets:
  - S_n=1, R_n=1, busy=0, conflict=0, pulse_cnt=0.
  - Synchronizer flops = 0, debounced levels = 0, debounce counters = 0.
  - Pending flags = 0, FSM = IDLE.
- Reset mid-pulse or mid-gap aborts immediately; outputs go high on the same edge.
- Each button passes through a 2-flop synchronizer, then the debouncer.
- Debounce:
  - The counter increments while the synced level differs from the debounced level.
  - It clears on any cycle they match.
  - When the counter reaches DEB_CYCLES-1 while still mismatched, the debounced level flips and the counter clears.
- Request: a one-cycle strobe on each debounced rising edge. Falling edges are ignored.
- Pending flags: set_pend and rst_pend, one deep each.
  - A strobe sets its flag.
  - A repeat strobe while the flag is already set is merged (dropped).
- FSM states: IDLE, SET_PULSE, RST_PULSE, GAP.
- IDLE:
  - If rst_pend=1, go to RST_PULSE and clear rst_pend. rst_pend has priority.
  - Else if set_pend=1, go to SET_PULSE and clear set_pend.
  - A strobe arriving in IDLE is taken on the next cycle; this cycle is counted in the latency figure below.
- SET_PULSE / RST_PULSE:
  - Drive S_n=0 (or R_n=0) for exactly PULSE_W cycles, then go to GAP.
- GAP: both outputs high for exactly GAP_W cycles, then return to IDLE.
- Outputs are registered from the next-state, so S_n and R_n transition on the same edge the state is entered.
- Invariant: S_n=0 and R_n=0 never occur on the same cycle.
- Simultaneous set and reset strobes on one cycle:
  - Both pending flags are set.
  - conflict pulses high for 1 cycle.
  - Service order is reset first, then set.
- Latency: from btn_set first sampled high (and held stable) to S_n=0 is DEB_CYCLES+3 clk edges when idle.
- Timing width: the debounce counter is $clog2(DEB_CYCLES+1) bits. The pulse/gap counter is $clog2(max(PULSE_W,GAP_W)+1) bits.

Optional Feature:
- Macro: SR_DRV_PULSE_CNT_EN.
- When defined:
  - Port pulse_cnt[7:0] exists.
  - It increments by 1 on each entry into SET_PULSE or RST_PULSE.
  - It wraps 255->0 and is cleared by rst.
- When undefined: the port and the counter logic are absent.
- All other behaviour is identical either way.

Decomposition:
- Package sr_drv_pkg holds:
  - FSM state encoding (IDLE=2'd0, SET_PULSE=2'd1, RST_PULSE=2'd2, GAP=2'd3).
  - The default parameter constants.
- Sub-module sr_debounce: synchronizer, debounce counter and rising-edge strobe. It is parameterised by DEB_CYCLES, with one instance per button.
- The FSM, pending flags and optional counter stay in the top module.

Test Plan:
All scenarios use DEB_CYCLES=4, PULSE_W=3, GAP_W=2.
1. Reset: hold rst for 2 cycles with both buttons high -> S_n=R_n=1, busy=0, pulse_cnt=0 throughout. No pulse until the buttons are released and re-pressed after rst.
2. Clean set press: btn_set held high from cycle 0 -> S_n=0 on edges 7..9, S_n=1 from edge 10, R_n=1 always, busy high for 5 cycles.
3. Bounce: btn_set toggles every 2 cycles for 20 cycles, then stays high -> no pulse during the toggling; exactly one S_n pulse at DEB_CYCLES+3 edges after the final rise.
4. Simultaneous press: both buttons rise on the same cycle -> conflict pulses once. R_n is low for 3 cycles, then a 2-cycle gap, then S_n low for 3 cycles. S_n&R_n never both 0.
5. Request during pulse: btn_rst debounced while S_n is low -> the R_n pulse starts immediately after the GAP. A second rst press during the same window is merged, giving a single R_n pulse.
6. With SR_DRV_PULSE_CNT_EN: 257 alternating set/reset events -> pulse_cnt=1. Mid-pulse rst -> S_n returns to 1 on that edge and pulse_cnt=0.
